// File: rtl/fetch_unit_pkg.sv
// Shared constants, helper widths and response classification for the fetch front end.
package fetch_unit_pkg;

  localparam int INST_BYTES = 4;

  // Pointer width for a FIFO of the given depth; at least one bit even for depth 1.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_PUSH = 2'd1,
    RSP_DROP = 2'd2
  } rsp_kind_e;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO with push/pop/flush, occupancy count and full/empty flags.
// Holds both the instruction queue and the per-request PC tags.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Explicit wrap so depths that are not a power of two stay correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full      = (int'(count_q) == DEPTH);
    empty     = (count_q == '0);
    count     = count_q;
    head_data = mem_q[rd_ptr_q];
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !flush) |-> (!full || pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues imem requests under a credit
// limit, queues in-order responses and hands {inst, pc, pc+4} to decode.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue feeds decode directly.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_inc
);

  localparam int              OCW     = cnt_w(MAX_OUT);
  localparam int              QCW     = cnt_w(DEPTH);
  localparam int              EW      = 32 + 2 * XLEN;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OCW-1:0]  out_cnt_q, out_cnt_d;
  logic [OCW-1:0]  drop_cnt_q, drop_cnt_d;

  logic            credit_ok, issue_fire, pop_fire, byp;
  rsp_kind_e       rsp_kind;
  logic [XLEN-1:0] rsp_pc;
  logic [EW-1:0]   rsp_entry;

  logic            q_push, q_pop, q_full, q_empty;
  logic [QCW-1:0]  q_count;
  logic [EW-1:0]   q_head;

  logic            tag_full, tag_empty;
  logic [OCW-1:0]  tag_count;

  fetch_unit_fifo #(.W(EW), .DEPTH(DEPTH)) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (rsp_entry),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head_data (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // One tag per outstanding request; dropped responses still retire their tag.
  fetch_unit_fifo #(.W(XLEN), .DEPTH(MAX_OUT)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (issue_fire),
    .push_data (fetch_pc_q),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .head_data (rsp_pc),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_comb begin
    // Credits use registered counts only, so a pop never frees a slot in the same cycle.
    credit_ok      = (int'(out_cnt_q) < MAX_OUT) &&
                     (int'(out_cnt_q) + int'(q_count) < DEPTH);
    imem_req_valid = !rst && !redirect_valid && credit_ok;
    imem_req_addr  = fetch_pc_q;
    issue_fire     = imem_req_valid && imem_req_ready;

    if (!imem_rsp_valid)                          rsp_kind = RSP_NONE;
    else if (redirect_valid || drop_cnt_q != '0)  rsp_kind = RSP_DROP;
    else                                          rsp_kind = RSP_PUSH;
    rsp_entry = {imem_rsp_data, rsp_pc, rsp_pc + PC_STEP};

`ifdef FETCH_BYPASS_EN
    byp = !rst && q_empty && (rsp_kind == RSP_PUSH);
`else
    byp = 1'b0;
`endif

    inst_valid = !rst && !redirect_valid && (!q_empty || byp);
    if (!inst_valid)  {inst_data, inst_pc, inst_pc_inc} = '0;
    else if (q_empty) {inst_data, inst_pc, inst_pc_inc} = rsp_entry;
    else              {inst_data, inst_pc, inst_pc_inc} = q_head;

    pop_fire = inst_valid && inst_ready;
    q_pop    = pop_fire && !q_empty;
    q_push   = (rsp_kind == RSP_PUSH) && !(byp && pop_fire);

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc & ~XLEN'(3);
    else if (issue_fire) fetch_pc_d = fetch_pc_q + PC_STEP;

    out_cnt_d = out_cnt_q + OCW'(issue_fire) - OCW'(imem_rsp_valid);

    // drop_cnt is a subset of out_cnt, so after a redirect every request still
    // in flight is stale; this also makes back-to-back redirects accumulate right.
    if (redirect_valid)             drop_cnt_d = out_cnt_d;
    else if (rsp_kind == RSP_DROP)  drop_cnt_d = drop_cnt_q - OCW'(1);
    else                            drop_cnt_d = drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (out_cnt_q != '0 && !tag_empty));
  a_tag_tracks: assert property (@(posedge clk) disable iff (rst)
    (tag_count == out_cnt_q) && !(issue_fire && tag_full && !imem_rsp_valid));
  a_q_no_overflow: assert property (@(posedge clk) disable iff (rst)
    q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued on issue and
// compared when decode pops; a second instance covers PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc, inst_pc_inc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data  = '0;
  logic        w_inst_valid;
  logic [31:0] w_inst_data, w_inst_pc, w_inst_pc_inc;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc_inc(inst_pc_inc)
  );

  fetch_unit #(.XLEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(w_inst_valid), .inst_ready(1'b1),
    .inst_data(w_inst_data), .inst_pc(w_inst_pc), .inst_pc_inc(w_inst_pc_inc)
  );

`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       mem_q[$];
  pend_t       w_q[$];
  logic [31:0] sb_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_pc;

  int vectors = 0, miscompares = 0;
  int cyc = 0, lat = 1, issued = 0, pops = 0, w_pops = 0;
  int first_rsp_cyc = -1;
  bit lat_arm = 0;
  logic last_req_valid, last_inst_valid;
  logic [31:0] last_inst_pc;

  logic        k_rst = 1'b1, k_req_ready = 1'b0, k_inst_ready = 1'b0, k_redirect = 1'b0;
  logic [31:0] k_redirect_pc = '0;

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return {pc[23:0], 8'h13};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs are sampled 1 ns later.
  task automatic tick();
    int d;
    logic [31:0] e;
    @(negedge clk);
    rst            = k_rst;
    imem_req_ready = k_req_ready;
    inst_ready     = k_inst_ready;
    redirect_valid = k_redirect;
    redirect_pc    = k_redirect_pc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    w_rsp_valid    = 1'b0;
    w_rsp_data     = '0;
    if (!k_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(mem_q[0].addr);
      void'(mem_q.pop_front());
      if (lat_arm && first_rsp_cyc < 0) first_rsp_cyc = cyc;
    end
    if (!k_rst && w_q.size() > 0 && w_q[0].due <= cyc) begin
      w_rsp_valid = 1'b1;
      w_rsp_data  = data_of(w_q[0].addr);
      void'(w_q.pop_front());
    end
    #1;
    last_req_valid  = imem_req_valid;
    last_inst_valid = inst_valid;
    last_inst_pc    = inst_pc;
    if (rst) begin
      mem_q.delete();
      w_q.delete();
    end else begin
      if (redirect_valid) begin
        check_eq("redirect_inst_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("redirect_req_valid", {31'b0, imem_req_valid}, 32'd0);
        sb_q.delete();
        exp_pc = redirect_pc & ~32'd3;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          check_eq("req_addr", imem_req_addr, exp_pc);
          mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
          sb_q.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
          issued++;
        end
        if (lat_arm && inst_valid) begin
          d = (first_rsp_cyc < 0) ? -1 : cyc - first_rsp_cyc;
          check_eq("first_latency", d, EXP_LAT);
          lat_arm = 0;
        end
        if (inst_valid && inst_ready) begin
          e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
          check_eq("inst_pc", inst_pc, e);
          check_eq("inst_data", inst_data, data_of(e));
          check_eq("inst_pc_inc", inst_pc_inc, e + 32'd4);
          pop_log.push_back(inst_pc);
          pops++;
        end
      end
      if (w_req_valid) w_q.push_back('{addr: w_req_addr, due: cyc + 1});
      if (w_inst_valid) begin
        if (w_pops == 0) begin
          check_eq("wrap_pc0", w_inst_pc, 32'hFFFF_FFFC);
          check_eq("wrap_inc0", w_inst_pc_inc, 32'h0000_0000);
          check_eq("wrap_data0", w_inst_data, data_of(32'hFFFF_FFFC));
        end else if (w_pops == 1) begin
          check_eq("wrap_pc1", w_inst_pc, 32'h0000_0000);
          check_eq("wrap_inc1", w_inst_pc_inc, 32'h0000_0004);
        end
        w_pops++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input logic req_rdy, input logic inst_rdy);
    k_rst = 1'b1; k_redirect = 1'b0; k_req_ready = 1'b0; k_inst_ready = 1'b0;
    tick();
    check_eq("rst_inst_valid", {31'b0, last_inst_valid}, 32'd0);
    tick();
    check_eq("rst_req_valid", {31'b0, last_req_valid}, 32'd0);
    check_eq("rst_inst_valid2", {31'b0, last_inst_valid}, 32'd0);
    check_eq("rst_req_addr", imem_req_addr, 32'h0);
    check_eq("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
    sb_q.delete();
    pop_log.delete();
    exp_pc = 32'h0; issued = 0; pops = 0; w_pops = 0; first_rsp_cyc = -1;
    k_rst = 1'b0; k_req_ready = req_rdy; k_inst_ready = inst_rdy;
    tick();
    check_eq("req_after_rst", {31'b0, last_req_valid}, 32'd1);
  endtask

  initial begin
    int bubbles, pops0, n;
    bit seen;

    // Reset and streaming with one-cycle memory
    lat = 1;
    lat_arm = 1;
    do_reset(1'b1, 1'b1);
    seen = 0; bubbles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_inst_valid) seen = 1;
      else if (seen) bubbles++;
    end
    check_eq("stream_started", {31'b0, seen}, 32'd1);
    check_eq("stream_bubbles", bubbles, 0);
    check_eq("stream_lat_done", {31'b0, lat_arm}, 32'd0);

    // Backpressure: queue fills to DEPTH, then drains in order
    lat = 1;
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    check_eq("bp_issued", issued, 4);
    check_eq("bp_req_valid", {31'b0, last_req_valid}, 32'd0);
    check_eq("bp_inst_valid", {31'b0, last_inst_valid}, 32'd1);
    check_eq("bp_head_pc", last_inst_pc, 32'h0);
    k_req_ready = 1'b0; k_inst_ready = 1'b1;
    pops0 = pops;
    for (int i = 0; i < 8; i++) tick();
    check_eq("bp_drained", pops - pops0, 4);
    check_eq("bp_empty", {31'b0, last_inst_valid}, 32'd0);

    // Redirect with two requests in flight
    lat = 3;
    do_reset(1'b1, 1'b1);
    n = 0;
    while (mem_q.size() < 2 && n < 10) begin tick(); n++; end
    check_eq("redir_outstanding", mem_q.size(), 2);
    k_redirect = 1'b1; k_redirect_pc = 32'h0000_0103;
    tick();
    k_redirect = 1'b0;
    pop_log.delete();
    for (int i = 0; i < 20; i++) tick();
    check_eq("redir_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hxxxx_xxxx, 32'h100);
    check_eq("redir_progress", {31'b0, pop_log.size() >= 4}, 32'd1);

    // Redirect in the same cycle as a response and a ready decode
    lat = 2;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    n = 0;
    while (!(mem_q.size() >= 2 && mem_q[0].due <= cyc) && n < 10) begin tick(); n++; end
    check_eq("same_setup", mem_q.size(), 2);
    pops0 = pops;
    k_redirect = 1'b1; k_redirect_pc = 32'h0000_0200;
    tick();
    k_redirect = 1'b0;
    check_eq("same_rsp_seen", {31'b0, imem_rsp_valid}, 32'd1);
    check_eq("same_no_pop", pops - pops0, 0);
    pop_log.delete();
    for (int i = 0; i < 15; i++) tick();
    check_eq("same_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hxxxx_xxxx, 32'h200);
    check_eq("wrap_pops", {31'b0, w_pops >= 2}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
